// File: rtl/lighthouse_pkg.sv
// Shared constants and types for the envelope UART path toward the host MCU.
package lighthouse_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hFF;

   // 24 MHz / 115200 baud, truncated
   localparam int UART_CLKS_PER_BIT = 208;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } frame_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-byte serializer. byte_ready is also high in the last stop-bit cycle
// so the next byte can be loaded with no idle gap on the line.
module uart_byte_tx
   import lighthouse_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic [7:0] byte_data,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] STOP_BIT = 4'd9;

   logic          active;
   logic [3:0]    bit_idx;
   logic [CW-1:0] clk_cnt;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end    = (clk_cnt == LAST_CLK);
   assign byte_ready = !active || (bit_end && (bit_idx == STOP_BIT));

   // shreg refills with ones, so after the eighth data bit it yields the stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= 1'b0;
         bit_idx <= '0;
         clk_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else if (byte_valid && byte_ready) begin
         active  <= 1'b1;
         bit_idx <= '0;
         clk_cnt <= '0;
         shreg   <= byte_data;
         tx      <= 1'b0;
      end else if (active) begin
         if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == STOP_BIT) begin
               active  <= 1'b0;
               bit_idx <= '0;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               tx      <= shreg[0];
               shreg   <= {1'b1, shreg[7:1]};
            end
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/envelope_uart_tx.sv
// Envelope stream to UART frame bridge: serializes each 64-bit envelope as 8 bytes
// and interleaves all-ones sync frames so the host can realign.
module envelope_uart_tx
   import lighthouse_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FRAME_BYTES  = 8,
   parameter int SYNC_PERIOD  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [8*FRAME_BYTES-1:0] envelope_data,
   input  logic                     envelope_valid,
   output logic                     envelope_ready,
   output logic                     tx,
   output logic                     busy
);

   localparam int DW = 8 * FRAME_BYTES;
   localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int CW = (SYNC_PERIOD > 0) ? $clog2(SYNC_PERIOD + 1) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);

   frame_state_e  state, state_n;
   logic          sync_pending, sync_pending_n;
   logic [CW-1:0] frame_cnt, frame_cnt_n;
   logic [BW-1:0] byte_idx, byte_idx_n;
   logic [DW-1:0] shreg, shreg_n;
   logic          xfer;
   logic          byte_valid;
   logic          byte_ready;
   logic [7:0]    byte_data;

   assign xfer = envelope_valid && envelope_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         sync_pending   <= 1'b1;
         frame_cnt      <= '0;
         byte_idx       <= '0;
         shreg          <= '0;
         envelope_ready <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_n;
         sync_pending   <= sync_pending_n;
         frame_cnt      <= frame_cnt_n;
         byte_idx       <= byte_idx_n;
         shreg          <= shreg_n;
         envelope_ready <= (state_n == ST_IDLE) && !sync_pending_n;
         busy           <= (state_n != ST_IDLE);
      end
   end

   // Byte 0 goes straight to the serializer on the decision cycle; later bytes come
   // from shreg whenever the serializer reaches the last cycle of a stop bit.
   always_comb begin
      state_n        = state;
      sync_pending_n = sync_pending;
      frame_cnt_n    = frame_cnt;
      byte_idx_n     = byte_idx;
      shreg_n        = shreg;
      byte_valid     = 1'b0;
      byte_data      = SYNC_BYTE;
      case (state)
         ST_IDLE: begin
            if (sync_pending) begin
               state_n    = ST_SYNC;
               byte_valid = 1'b1;
               byte_idx_n = '0;
            end else if (xfer) begin
               state_n    = ST_DATA;
               byte_valid = 1'b1;
               byte_data  = envelope_data[7:0];
               byte_idx_n = '0;
               shreg_n    = envelope_data >> 8;
            end
         end
         ST_SYNC, ST_DATA: begin
            if (byte_ready) begin
               if (byte_idx == LAST_BYTE) begin
                  state_n = ST_IDLE;
                  if (state == ST_SYNC) begin
                     sync_pending_n = 1'b0;
                  end else if (SYNC_PERIOD != 0) begin
                     if (frame_cnt == CW'(SYNC_PERIOD - 1)) begin
                        frame_cnt_n    = '0;
                        sync_pending_n = 1'b1;
                     end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                     end
                  end
               end else begin
                  byte_valid = 1'b1;
                  byte_data  = (state == ST_SYNC) ? SYNC_BYTE : shreg[7:0];
                  shreg_n    = shreg >> 8;
                  byte_idx_n = byte_idx + 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk       (clk),
      .reset     (reset),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .byte_data (byte_data),
      .tx        (tx)
   );

endmodule

// File: tb/tb_envelope_uart_tx.sv
// Bench for envelope_uart_tx: a UART decoder scoreboard per instance, directed steps
// on a SYNC_PERIOD=2 instance and a SYNC_PERIOD=0 instance.
module tb_envelope_uart_tx;

   localparam int CPB = 4;
   localparam int FB  = 8;

   logic        clk = 1'b0;
   logic        rst_a, valid_a, ready_a, tx_a, busy_a;
   logic        rst_b, valid_b, ready_b, tx_b, busy_b;
   logic [63:0] data_a, data_b;

   always #5 clk = ~clk;

   envelope_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .SYNC_PERIOD(2)) dut_a (
      .clk(clk), .reset(rst_a), .envelope_data(data_a), .envelope_valid(valid_a),
      .envelope_ready(ready_a), .tx(tx_a), .busy(busy_a));

   envelope_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .SYNC_PERIOD(0)) dut_b (
      .clk(clk), .reset(rst_b), .envelope_data(data_b), .envelope_valid(valid_b),
      .envelope_ready(ready_b), .tx(tx_b), .busy(busy_b));

   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         fail_cnt = 0;
   logic [7:0] exq0[$];
   logic [7:0] exq1[$];
   int         gen[2];
   int         m_gen[2];
   bit         m_busy[2];
   int         m_cnt[2];
   logic [7:0] m_byte[2];
   int         bytes_rx[2];
   int         xfer_a = 0;
   int         xfer_b = 0;
   int         frames_b = 0;
   int         low_run_a = 0;
   logic       prev_a, prev_b;
   int         gaps[$];
   int         mcnt_a = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART line decoder: samples each bit mid-way, pops the expected byte on the stop bit
   always @(negedge clk) begin
      logic       txv;
      logic [7:0] e;
      int         k;
      for (int d = 0; d < 2; d++) begin
         txv = (d == 0) ? tx_a : tx_b;
         if (m_gen[d] != gen[d]) begin
            m_gen[d]  = gen[d];
            m_busy[d] = 1'b0;
         end else if (!m_busy[d]) begin
            if (txv === 1'b0) begin
               m_busy[d] = 1'b1;
               m_cnt[d]  = 0;
            end
         end else begin
            m_cnt[d]++;
            if (m_cnt[d] % CPB == CPB / 2) begin
               k = m_cnt[d] / CPB;
               if (k >= 1 && k <= 8) begin
                  m_byte[d][k-1] = txv;
               end else if (k == 9) begin
                  m_busy[d] = 1'b0;
                  bytes_rx[d]++;
                  check((d == 0) ? "stop_bit_a" : "stop_bit_b", 64'(txv), 64'd1);
                  if (d == 0) begin
                     check("rx_a_expected", 64'(exq0.size() != 0), 64'd1);
                     if (exq0.size() != 0) begin
                        e = exq0.pop_front();
                        check("rx_a_byte", 64'(m_byte[0]), 64'(e));
                     end
                  end else begin
                     check("rx_b_expected", 64'(exq1.size() != 0), 64'd1);
                     if (exq1.size() != 0) begin
                        e = exq1.pop_front();
                        check("rx_b_byte", 64'(m_byte[1]), 64'(e));
                     end
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (busy_a === 1'b1) begin
         if (prev_a === 1'b0) gaps.push_back(low_run_a);
         low_run_a = 0;
      end else begin
         low_run_a++;
      end
      prev_a = busy_a;
      if (busy_b === 1'b1 && prev_b === 1'b0) frames_b++;
      prev_b = busy_b;
   end

   always @(posedge clk) begin
      if (valid_a === 1'b1 && ready_a === 1'b1) xfer_a++;
      if (valid_b === 1'b1 && ready_b === 1'b1) xfer_b++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push_bytes(input int which, input logic [63:0] d);
      for (int k = 0; k < FB; k++) begin
         if (which == 0) exq0.push_back(d[8*k +: 8]);
         else exq1.push_back(d[8*k +: 8]);
      end
   endtask

   task automatic push_sync(input int which);
      push_bytes(which, {64{1'b1}});
   endtask

   task automatic accept(input int which, input logic [63:0] d, output int w);
      logic rdy;
      if (which == 0) begin valid_a = 1'b1; data_a = d; end
      else begin valid_b = 1'b1; data_b = d; end
      w = 0;
      rdy = (which == 0) ? ready_a : ready_b;
      while (rdy !== 1'b1 && w < 3000) begin
         @(negedge clk);
         w++;
         rdy = (which == 0) ? ready_a : ready_b;
      end
      check((which == 0) ? "accept_a" : "accept_b", 64'(rdy), 64'd1);
      if (rdy === 1'b1) begin
         push_bytes(which, d);
         if (which == 0) begin
            mcnt_a++;
            if (mcnt_a == 2) begin
               mcnt_a = 0;
               push_sync(0);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_busy(input int which, input logic lvl, input string tag);
      logic b;
      int   n;
      n = 0;
      b = (which == 0) ? busy_a : busy_b;
      while (b !== lvl && n < 3000) begin
         @(negedge clk);
         n++;
         b = (which == 0) ? busy_a : busy_b;
      end
      check(tag, 64'(b), 64'(lvl));
   endtask

   task automatic count_busy(output int n, output int rdy_hi);
      n = 0;
      rdy_hi = 0;
      while (busy_a === 1'b1 && n < 3000) begin
         n++;
         if (ready_a !== 1'b0) rdy_hi++;
         @(negedge clk);
      end
   endtask

   initial begin
      int          n, rh, w, x0;
      logic [63:0] d;
      rst_a = 1'b1; rst_b = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0;
      data_a = '0; data_b = '0;

      // reset values, then the post-reset sync frame
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", 64'(tx_a), 64'd1);
      check("reset_ready", 64'(ready_a), 64'd0);
      check("reset_busy", 64'(busy_a), 64'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      push_sync(0);
      @(negedge clk);
      check("idle_tx", 64'(tx_a), 64'd1);
      check("idle_busy", 64'(busy_a), 64'd0);
      check("idle_ready", 64'(ready_a), 64'd0);
      @(negedge clk);
      check("sync_start_tx", 64'(tx_a), 64'd0);
      check("sync_start_busy", 64'(busy_a), 64'd1);
      count_busy(n, rh);
      check("sync_len", 64'(n), 64'd320);
      check("sync_ready_low", 64'(rh), 64'd0);
      check("post_sync_ready", 64'(ready_a), 64'd1);
      check("post_sync_tx", 64'(tx_a), 64'd1);
      check("sync_bytes_done", 64'(exq0.size()), 64'd0);

      // single envelope, byte order and frame length
      x0 = xfer_a;
      accept(0, 64'h0807060504030201, w);
      valid_a = 1'b0;
      data_a = 64'hDEADBEEFDEADBEEF;
      @(negedge clk);
      check("data_start_tx", 64'(tx_a), 64'd0);
      check("data_start_ready", 64'(ready_a), 64'd0);
      count_busy(n, rh);
      check("data_len", 64'(n), 64'd320);
      check("data_ready_low", 64'(rh), 64'd0);
      check("data_xfer_once", 64'(xfer_a - x0), 64'd1);
      check("data_bytes_done", 64'(exq0.size()), 64'd0);

      // reset during byte 3 (0x00) of a data frame
      x0 = xfer_a;
      accept(0, 64'h11223344_00AABBCC, w);
      valid_a = 1'b0;
      repeat (130) @(posedge clk);
      @(negedge clk);
      check("pre_abort_tx", 64'(tx_a), 64'd0);
      rst_a = 1'b1;
      gen[0]++;
      exq0.delete();
      push_sync(0);
      mcnt_a = 0;
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(negedge clk);
      check("abort_tx", 64'(tx_a), 64'd1);
      check("abort_busy", 64'(busy_a), 64'd0);
      @(negedge clk);
      check("resync_start_tx", 64'(tx_a), 64'd0);
      wait_busy(0, 1'b0, "resync_end");
      check("resync_bytes_done", 64'(exq0.size()), 64'd0);
      rh = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy_a !== 1'b0) rh++;
      end
      check("no_retransmit", 64'(rh), 64'd0);
      check("abort_xfer_once", 64'(xfer_a - x0), 64'd1);

      // valid held high: data0, data1, sync, data2 with one-cycle gaps
      x0 = xfer_a;
      accept(0, 64'hA0A1A2A3A4A5A6A7, w);
      repeat (5) @(negedge clk);
      gaps.delete();
      accept(0, 64'h0123456789ABCDEF, w);
      accept(0, 64'hFEDCBA9876543210, w);
      valid_a = 1'b0;
      wait_busy(0, 1'b0, "held_end");
      check("held_gap_count", 64'(gaps.size()), 64'd3);
      foreach (gaps[i]) check("held_gap", 64'(gaps[i]), 64'd1);
      check("held_bytes_done", 64'(exq0.size()), 64'd0);
      check("held_xfer_count", 64'(xfer_a - x0), 64'd3);

      // valid raised in the middle of a sync frame
      accept(0, 64'h5555AAAA3333CCCC, w);
      valid_a = 1'b0;
      wait_busy(0, 1'b0, "pre_sync_frame_end");
      wait_busy(0, 1'b1, "mid_sync_start");
      repeat (100) @(negedge clk);
      valid_a = 1'b1;
      data_a = 64'h0F1E2D3C4B5A6978;
      n = 0;
      rh = 0;
      while (busy_a === 1'b1 && n < 3000) begin
         if (ready_a !== 1'b0) rh++;
         @(negedge clk);
         n++;
      end
      check("mid_sync_ready_low", 64'(rh), 64'd0);
      check("ready_first_idle", 64'(ready_a), 64'd1);
      accept(0, 64'h0F1E2D3C4B5A6978, w);
      check("accept_first_idle", 64'(w), 64'd0);
      valid_a = 1'b0;
      wait_busy(0, 1'b0, "mid_sync_data_end");
      check("mid_sync_bytes_done", 64'(exq0.size()), 64'd0);

      // SYNC_PERIOD=0: one sync after reset, then 20 data frames
      @(posedge clk); #1;
      rst_b = 1'b0;
      push_sync(1);
      for (int i = 0; i < 20; i++) begin
         d = {$urandom(), $urandom()};
         accept(1, d, w);
      end
      valid_b = 1'b0;
      wait_busy(1, 1'b0, "b_end");
      check("b_bytes_done", 64'(exq1.size()), 64'd0);
      check("b_byte_count", 64'(bytes_rx[1]), 64'd168);
      check("b_xfer_count", 64'(xfer_b), 64'd20);
      check("b_frame_count", 64'(frames_b), 64'd21);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
